// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared FSM state type, default operand width and datapath strobe-vector width for the shift-add multiplier
package mult_seq_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ADD    = 3'd2,
    SHIFT  = 3'd3,
    FINISH = 3'd4,
    DONE   = 3'd5
  } state_e;
  localparam int DEF_WIDTH = 4;
  localparam int STROBE_W = 5;
endpackage

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: shift-add multiplier sequencer (in: start/abort/b_lsb; out: ld_ab, clr_acc, add_en, shift_en, out_en, busy, done, iter)
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             b_lsb,
  output logic             ld_ab,
  output logic             clr_acc,
  output logic             add_en,
  output logic             shift_en,
  output logic             out_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d  = IDLE;
    cnt_d    = cnt_q;
    ld_ab    = 1'b0;
    clr_acc  = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    out_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE:   state_d = (start && !abort) ? LOAD : IDLE;
      LOAD: begin
        ld_ab   = 1'b1;
        clr_acc = 1'b1;
        busy    = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        add_en  = b_lsb;
        busy    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = (cnt_q == CNT_W'(WIDTH - 1)) ? FINISH : ADD;
      end
      FINISH: begin
        out_en  = 1'b1;
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = (start && !abort) ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort && busy) state_d = IDLE;
    if (state_d == IDLE || state_d == LOAD) cnt_d = '0;
  end
  assign iter = cnt_q;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: scoreboard bench for the multiplier sequencer at WIDTH 4, 2 and 8
module tb_mult_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic [3:0] a_pin, b_pin;
  logic ld4, clr4, add4, sh4, out4, busy4, done4;
  logic [2:0] iter4;
  logic ld2, clr2, add2, sh2, out2, busy2, done2;
  logic [1:0] iter2;
  logic ld8, clr8, add8, sh8, out8, busy8, done8;
  logic [3:0] iter8;
  logic [3:0] a_r = '0;
  logic [3:0] b_sr = '0;
  logic [4:0] hi = '0;
  logic [7:0] prod = '0;
  logic [7:0] sb[$];
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mult_seq_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .b_lsb(b_sr[0]),
    .ld_ab(ld4), .clr_acc(clr4), .add_en(add4), .shift_en(sh4), .out_en(out4),
    .busy(busy4), .done(done4), .iter(iter4)
  );
  mult_seq_ctrl #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .b_lsb(1'b1),
    .ld_ab(ld2), .clr_acc(clr2), .add_en(add2), .shift_en(sh2), .out_en(out2),
    .busy(busy2), .done(done2), .iter(iter2)
  );
  mult_seq_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .b_lsb(1'b1),
    .ld_ab(ld8), .clr_acc(clr8), .add_en(add8), .shift_en(sh8), .out_en(out8),
    .busy(busy8), .done(done8), .iter(iter8)
  );
  always @(posedge clk) begin
    if (ld4) begin
      a_r  <= a_pin;
      b_sr <= b_pin;
    end
    if (clr4) hi <= '0;
    if (add4) hi <= hi + {1'b0, a_r};
    if (sh4) {hi, b_sr} <= {hi, b_sr} >> 1;
    if (out4) prod <= {hi[3:0], b_sr};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] exp_vec(input int r, input int w, input logic [7:0] b);
    if (r == 1) return 7'b1100010;
    if (r >= 2 && r <= 2 * w + 1) return (r % 2 == 0) ? {2'b00, b[(r-2)/2], 4'b0010} : 7'b0001010;
    if (r == 2 * w + 2) return 7'b0000110;
    if (r == 2 * w + 3) return 7'b0000001;
    return 7'b0;
  endfunction
  function automatic int exp_iter(input int r, input int w);
    if (r >= 2 && r <= 2 * w + 1) return (r - 2) / 2;
    if (r == 2 * w + 2 || r == 2 * w + 3) return w;
    return 0;
  endfunction
  task automatic chk4(input int r, input logic [3:0] b);
    chk($sformatf("vec4@%0d", r), 32'({ld4, clr4, add4, sh4, out4, busy4, done4}), 32'(exp_vec(r, 4, {4'b0, b})));
    chk($sformatf("iter4@%0d", r), 32'(iter4), 32'(exp_iter(r, 4)));
  endtask
  task automatic chk_idle(input string tag);
    chk(tag, 32'({ld4, clr4, add4, sh4, out4, busy4, done4, iter4}), 0);
  endtask
  always @(negedge clk) begin
    if (done4) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("prod", 32'(prod), 32'(sb.pop_front()));
    end
    if (rst_n) begin
      chk("excl4", 32'($onehot0({ld4, add4, sh4, out4}) && (!clr4 || ld4)), 1);
      chk("excl2", 32'($onehot0({ld2, add2, sh2, out2}) && (!clr2 || ld2)), 1);
      chk("excl8", 32'($onehot0({ld8, add8, sh8, out8}) && (!clr8 || ld8)), 1);
    end
  end
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input int n);
    a_pin = a;
    b_pin = b;
    start = 1'b1;
    sb.push_back(8'(a) * 8'(b));
    chk4(0, b);
    for (int r = 1; r <= n; r++) begin
      @(negedge clk);
      start = 1'b0;
      chk4(r, b);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a_pin = '0;
    b_pin = '0;
    repeat (3) @(negedge clk);
    chk_idle("in_reset");
    rst_n = 1'b1;
    #1 chk_idle("release");
    @(negedge clk);
    chk_idle("first_cycle");
    run4(4'd13, 4'b1011, 12);
    run4(4'd9, 4'b0000, 12);
    a_pin = 4'd5;
    b_pin = 4'd6;
    start = 1'b1;
    sb.push_back(8'd30);
    chk4(0, 4'd6);
    for (int r = 1; r <= 23; r++) begin
      @(negedge clk);
      start = (r >= 6 && r <= 11);
      if (r <= 11) chk4(r, 4'd6);
      else chk4(r - 11, 4'b1001);
      if (r == 11) begin
        a_pin = 4'd7;
        b_pin = 4'b1001;
        sb.push_back(8'd63);
      end
    end
    a_pin = 4'd3;
    b_pin = 4'hf;
    start = 1'b1;
    for (int r = 1; r <= 15; r++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (r == 4);
      if (r <= 4) chk4(r, 4'hf);
      else chk_idle($sformatf("abort@%0d", r));
    end
    abort = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk_idle($sformatf("abort_start@%0d", r));
    end
    run4(4'd11, 4'd14, 5);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_rst");
    chk("async_rst8", 32'({ld8, clr8, add8, sh8, out8, busy8, done8, iter8}), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 15; r++) begin
      chk_idle($sformatf("post_rst@%0d", r));
      @(negedge clk);
    end
    a_pin = 4'd15;
    b_pin = 4'd15;
    start = 1'b1;
    sb.push_back(8'd225);
    for (int r = 1; r <= 21; r++) begin
      @(negedge clk);
      start = 1'b0;
      chk4(r, 4'd15);
      chk($sformatf("vec2@%0d", r), 32'({ld2, clr2, add2, sh2, out2, busy2, done2}), 32'(exp_vec(r, 2, 8'hff)));
      chk($sformatf("vec8@%0d", r), 32'({ld8, clr8, add8, sh8, out8, busy8, done8}), 32'(exp_vec(r, 8, 8'hff)));
      chk($sformatf("iter8@%0d", r), 32'(iter8), 32'(exp_iter(r, 8)));
      chk($sformatf("done2@%0d", r), 32'(done2), 32'(r == 7));
      chk($sformatf("done8@%0d", r), 32'(done8), 32'(r == 19));
    end
    chk("sb_drain", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
